// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready front end for a 1rw1r SRAM macro with per-port response FIFOs.
// Define SRAM_REQ_CTRL_STATS_EN to add saturating transaction/conflict counters.
module sram_rsp_port #(
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  rready,
    output logic                  credit,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    logic                  pend;
    logic [CW-1:0]         count;
    logic [PW-1:0]         wptr, rptr;
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] last;
    logic                  empty, pop, fifo_pop, push;
    assign empty    = count == '0;
    assign credit   = (count + CW'(pend)) < CW'(RSP_DEPTH);
    assign rvalid   = !reset && (!empty || pend);
    // An empty FIFO forwards the macro output directly so a read responds the very next cycle.
    assign rdata    = !empty ? mem[rptr] : pend ? dout : last;
    assign pop      = rvalid && rready;
    assign fifo_pop = pop && !empty;
    assign push     = pend && !(empty && pop);
    always_ff @(posedge clk)
        if (push) mem[wptr] <= dout;
    always_ff @(posedge clk) begin
        if (reset) begin
            pend  <= 1'b0;
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            last  <= '0;
        end else begin
            pend  <= issue;
            count <= count + CW'(push) - CW'(fifo_pop);
            if (push) wptr <= wptr + PW'(1);
            if (fifo_pop) rptr <= rptr + PW'(1);
            if (pop) last <= rdata;
        end
    end
endmodule

module sram_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [NUM_WMASKS-1:0] p0_wmask,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rvalid,
    input  logic                  p0_rready,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic                  p1_rvalid,
    input  logic                  p1_rready,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef SRAM_REQ_CTRL_STATS_EN
    ,
    output logic [31:0]           stat_rd0,
    output logic [31:0]           stat_wr0,
    output logic [31:0]           stat_rd1,
    output logic [31:0]           stat_conflict
`endif
);
    logic credit0, credit1, acc0, acc1, conflict;
    // A same-cycle write to the address port 1 wants to read would race the macro; the write wins.
    assign conflict    = p0_valid && p0_we && (p0_addr == p1_addr);
    assign p0_ready    = !reset && (p0_we || credit0);
    assign p1_ready    = !reset && credit1 && !conflict;
    assign acc0        = p0_valid && p0_ready;
    assign acc1        = p1_valid && p1_ready;
    assign sram_csb0   = !acc0;
    assign sram_web0   = !(acc0 && p0_we);
    assign sram_wmask0 = p0_wmask;
    assign sram_addr0  = p0_addr;
    assign sram_din0   = p0_wdata;
    assign sram_csb1   = !acc1;
    assign sram_addr1  = p1_addr;

    sram_rsp_port #(.DATA_WIDTH(DATA_WIDTH), .RSP_DEPTH(RSP_DEPTH)) u_rsp0 (
        .clk(clk), .reset(reset), .issue(acc0 && !p0_we), .dout(sram_dout0), .rready(p0_rready),
        .credit(credit0), .rvalid(p0_rvalid), .rdata(p0_rdata)
    );
    sram_rsp_port #(.DATA_WIDTH(DATA_WIDTH), .RSP_DEPTH(RSP_DEPTH)) u_rsp1 (
        .clk(clk), .reset(reset), .issue(acc1), .dout(sram_dout1), .rready(p1_rready),
        .credit(credit1), .rvalid(p1_rvalid), .rdata(p1_rdata)
    );

`ifdef SRAM_REQ_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd0      <= '0;
            stat_wr0      <= '0;
            stat_rd1      <= '0;
            stat_conflict <= '0;
        end else begin
            if (acc0 && !p0_we && stat_rd0 != '1) stat_rd0 <= stat_rd0 + 32'd1;
            if (acc0 && p0_we && stat_wr0 != '1) stat_wr0 <= stat_wr0 + 32'd1;
            if (acc1 && stat_rd1 != '1) stat_rd1 <= stat_rd1 + 32'd1;
            if (p1_valid && conflict && stat_conflict != '1) stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed and random stimulus for sram_req_ctrl against a queue-based reference.
module tb_sram_req_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, p0_valid, p0_we, p0_rready, p1_valid, p1_rready;
    logic [3:0]  p0_wmask;
    logic [8:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata;
    logic        p0_ready, p0_rvalid, p1_ready, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        sram_csb0, sram_web0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0 = '0, sram_dout1 = '0;

    sram_req_ctrl dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_wmask(p0_wmask),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rready(p0_rready),
        .p0_rdata(p0_rdata), .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr),
        .p1_rvalid(p1_rvalid), .p1_rready(p1_rready), .p1_rdata(p1_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // Behavioural 1rw1r macro: pins registered on the rising edge, read data valid the next cycle.
    logic [31:0] macro_mem [512] = '{default: 32'h0};
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) macro_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else sram_dout0 <= macro_mem[sram_addr0];
        end
        if (!sram_csb1) sram_dout1 <= macro_mem[sram_addr1];
    end

    int          errors = 0, checks = 0;
    logic [31:0] ref_mem [512] = '{default: 32'h0};
    logic [31:0] q0[$], q1[$];
    logic [31:0] last0 = '0, last1 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: compare outputs against the reference, then advance the reference.
    task automatic step();
        logic        conf, rdy0, rdy1, rv0, rv1, acc0, acc1;
        logic [31:0] e0, e1;
        #1;
        conf = p0_valid && p0_we && (p0_addr == p1_addr);
        rdy0 = !reset && (p0_we || q0.size() < 2);
        rdy1 = !reset && q1.size() < 2 && !conf;
        rv0  = !reset && q0.size() > 0;
        rv1  = !reset && q1.size() > 0;
        acc0 = p0_valid && rdy0;
        acc1 = p1_valid && rdy1;
        e0   = rv0 ? 32'h0 : last0;
        e1   = rv1 ? 32'h0 : last1;
        if (rv0) e0 = q0[0];
        if (rv1) e1 = q1[0];
        chk("p0_ready", 32'(p0_ready), 32'(rdy0));
        chk("p1_ready", 32'(p1_ready), 32'(rdy1));
        chk("p0_rvalid", 32'(p0_rvalid), 32'(rv0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(rv1));
        chk("csb0", 32'(sram_csb0), 32'(!acc0));
        chk("web0", 32'(sram_web0), 32'(!(acc0 && p0_we)));
        chk("csb1", 32'(sram_csb1), 32'(!acc1));
        chk("addr0", 32'(sram_addr0), 32'(p0_addr));
        chk("addr1", 32'(sram_addr1), 32'(p1_addr));
        chk("din0", sram_din0, p0_wdata);
        chk("wmask0", 32'(sram_wmask0), 32'(p0_wmask));
        if (!reset) begin
            chk("p0_rdata", p0_rdata, e0);
            chk("p1_rdata", p1_rdata, e1);
        end
        if (reset) begin
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
        end else begin
            if (rv0 && p0_rready) last0 = q0.pop_front();
            if (rv1 && p1_rready) last1 = q1.pop_front();
            if (acc1) q1.push_back(ref_mem[p1_addr]);
            if (acc0 && !p0_we) q0.push_back(ref_mem[p0_addr]);
            if (acc0 && p0_we)
                for (int b = 0; b < 4; b++)
                    if (p0_wmask[b]) ref_mem[p0_addr][8*b +: 8] = p0_wdata[8*b +: 8];
        end
        @(negedge clk);
    endtask

    task automatic wr0(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = a; p0_wdata = d; p0_wmask = m;
    endtask

    task automatic rd0(input logic [8:0] a);
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = a;
    endtask

    initial begin
        int          nvalid;
        logic [8:0]  wa;
        reset = 1'b1; p0_valid = 1'b0; p0_we = 1'b0; p0_wmask = '0; p0_addr = '0; p0_wdata = '0;
        p0_rready = 1'b1; p1_valid = 1'b0; p1_addr = '0; p1_rready = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_csb0", 32'(sram_csb0), 32'h1);
        step();

        // write then read-after-write on port 0
        wr0(9'h005, 32'hDEADBEEF, 4'hF);
        step();
        rd0(9'h005);
        step();
        p0_valid = 1'b0;
        #1;
        chk("raw_rvalid", 32'(p0_rvalid), 32'h1);
        chk("raw_rdata", p0_rdata, 32'hDEADBEEF);
        step();

        // byte-masked write observed through port 1
        wr0(9'h010, 32'h11223344, 4'hF);
        step();
        wr0(9'h010, 32'hAABBCCDD, 4'h5);
        step();
        p0_valid = 1'b0; p1_valid = 1'b1; p1_addr = 9'h010;
        step();
        p1_valid = 1'b0;
        #1;
        chk("mask_rvalid", 32'(p1_rvalid), 32'h1);
        chk("mask_rdata", p1_rdata, 32'h11BB33DD);
        step();

        // backpressure: two reads fill the credits, the third waits for rready
        p0_rready = 1'b0;
        rd0(9'h005);
        step();
        rd0(9'h010);
        step();
        rd0(9'h005);
        #1;
        chk("bp_third_stall", 32'(p0_ready), 32'h0);
        step();
        step();
        p0_rready = 1'b1;
        #1;
        chk("bp_release_stall", 32'(p0_ready), 32'h0);
        chk("bp_first_data", p0_rdata, 32'hDEADBEEF);
        step();
        #1;
        chk("bp_third_accept", 32'(p0_ready), 32'h1);
        chk("bp_second_data", p0_rdata, 32'h11BB33DD);
        step();
        p0_valid = 1'b0;
        #1;
        chk("bp_third_data", p0_rdata, 32'hDEADBEEF);
        step();
        step();

        // write/read conflict on the same address
        wr0(9'h1FF, 32'hCAFEF00D, 4'hF);
        p1_valid = 1'b1; p1_addr = 9'h1FF;
        #1;
        chk("conf_p1_stall", 32'(p1_ready), 32'h0);
        step();
        p0_valid = 1'b0;
        #1;
        chk("conf_p1_retry", 32'(p1_ready), 32'h1);
        step();
        p1_valid = 1'b0;
        #1;
        chk("conf_rdata", p1_rdata, 32'hCAFEF00D);
        step();

        // reset while a read is in flight
        rd0(9'h005);
        step();
        p0_valid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst_mid_rvalid", 32'(p0_rvalid), 32'h0);
        chk("rst_mid_csb0", 32'(sram_csb0), 32'h1);
        chk("rst_mid_csb1", 32'(sram_csb1), 32'h1);
        step();
        #1;
        chk("rst_mid_rvalid2", 32'(p0_rvalid), 32'h0);
        step();

        // address wrap on port 1 with continuous consumption
        for (int i = 0; i < 6; i++) begin
            wa = 9'(9'h1FD + i);
            wr0(wa, $urandom, 4'hF);
            step();
        end
        p0_valid = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            p1_valid = i < 6;
            p1_addr  = 9'(9'h1FD + i);
            #1;
            if (p1_rvalid) nvalid++;
            if (i < 6) chk("wrap_ready", 32'(p1_ready), 32'h1);
            step();
        end
        chk("wrap_count", 32'(nvalid), 32'd6);

        // random traffic over a small address window to provoke hits and conflicts
        for (int i = 0; i < 600; i++) begin
            reset     = $urandom_range(0, 63) == 0;
            p0_valid  = 1'($urandom_range(0, 1));
            p0_we     = $urandom_range(0, 2) == 0;
            p0_wmask  = 4'($urandom);
            p0_addr   = 9'($urandom_range(0, 7));
            p0_wdata  = $urandom;
            p0_rready = $urandom_range(0, 3) != 0;
            p1_valid  = 1'($urandom_range(0, 1));
            p1_addr   = 9'($urandom_range(0, 7));
            p1_rready = $urandom_range(0, 3) != 0;
            step();
        end
        reset = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0; p0_rready = 1'b1; p1_rready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Initiator-side controller for the 1rw1r 32x512 SRAM macro. Turns two valid/ready request channels into macro pin activity:
  - port 0 read/write (p0_*)
  - port 1 read-only (p1_*)
- Captures read data at the correct edge and returns it through per-port 2-entry response FIFOs with backpressure.
- Sits between core-side bus logic and the SRAM macro. The macro's clk0/clk1 are tied to clk.

Parameters:
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 9, word address width
- NUM_WMASKS, 4, byte-lane write mask width (DATA_WIDTH/8)
- RSP_DEPTH, 2, response FIFO entries per port (power of two, ≥2)

Ports:
- clk  in  1  single clock; also drives macro clk0/clk1
- reset  in  1  synchronous, active-high reset
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle when p0_valid is also high
- p0_we  in  1  1 = write, 0 = read
- p0_wmask  in  NUM_WMASKS  byte-lane enables for writes
- p0_addr  in  ADDR_WIDTH  word address
- p0_wdata  in  DATA_WIDTH  write data
- p0_rvalid  out  1  port 0 read response valid
- p0_rready  in  1  consumer accepts the port 0 response
- p0_rdata  out  DATA_WIDTH  port 0 read data
- p1_valid  in  1  port 1 read request valid
- p1_ready  out  1  port 1 request accepted
- p1_addr  in  ADDR_WIDTH  port 1 read address
- p1_rvalid  out  1  port 1 response valid
- p1_rready  in  1  port 1 response accept
- p1_rdata  out  DATA_WIDTH  port 1 read data
- sram_csb0, sram_web0  out  1 each  macro port 0 chip select / write enable (active low)
- sram_wmask0  out  NUM_WMASKS  macro write mask
- sram_addr0  out  ADDR_WIDTH  macro port 0 address
- sram_din0  out  DATA_WIDTH  macro write data
- sram_dout0  in  DATA_WIDTH  macro port 0 read data
- sram_csb1  out  1  macro port 1 chip select (active low)
- sram_addr1  out  ADDR_WIDTH  macro port 1 address
- sram_dout1  in  DATA_WIDTH  macro port 1 read data

Behaviour:
- Macro pin drive:
  - Macro pins are driven combinationally from the accepted request in the handshake cycle N. The macro registers them at the posedge ending cycle N.
  - sram_csb0 = !(p0_valid && p0_ready); sram_web0 = !p0_we when selected, else 1.
  - sram_addr0, sram_din0 and sram_wmask0 pass through from the request.
  - Port 1 pins follow the same scheme.
- Read latency:
  - A read accepted in cycle N sets a pending flag.
  - At posedge N+1 the controller samples sram_doutX into the response FIFO.
  - rvalid is high in cycle N+1 at the earliest: 1-cycle issue-to-response latency.
- Credit rule per port:
  - Reads accepted only when fifo_count + pending < RSP_DEPTH.
  - Responses are never dropped.
  - Responses return in request order per port.
- Writes:
  - p0_ready for a write ignores FIFO state.
  - Writes produce no response.
  - A read issued at N+1 to an address written at N returns the new data.
- Port 0 ready:
  - p0_ready = !reset && (p0_we || credit_available0).
- Conflict:
  - Port 0 write and port 1 read to the same address in the same cycle: write wins; p1_ready = 0 that cycle.
  - Port 1 retries next cycle.
  - Reads on both ports to the same address are allowed.
- FIFO:
  - Full: no new reads accepted.
  - Empty: rvalid = 0 and rdata holds its last value.
  - Simultaneous push and pop on a full FIFO is legal because credit accounts for pending.
  - Pointers wrap modulo RSP_DEPTH.
- Reset values:
  - sram_csb0 = sram_csb1 = 1, sram_web0 = 1.
  - p0_ready = p1_ready = 0 while reset is high.
  - p0_rvalid = p1_rvalid = 0; rdata = 0.
  - FIFO counts and pointers = 0; pending flags = 0.
- Reset mid-operation: in-flight reads are discarded; their data is not pushed after reset deasserts.
- Illegal: p0_we = 1 with p0_wmask = 0 is accepted; the macro sees csb0 = 0, web0 = 0 and writes no lanes.

Optional Feature:
- Macro: SRAM_REQ_CTRL_STATS_EN.
- Defined:
  - Adds 32-bit saturating counters, exposed as outputs: stat_rd0, stat_wr0, stat_rd1, stat_conflict.
  - Each counts accepted transactions and conflict stalls; all cleared by reset.
- Undefined: counters and their ports are absent; behaviour is otherwise identical.

Test Plan:
- Write p0 addr 0x005, data 0xDEADBEEF, wmask 0xF; read p0 addr 0x005 next cycle -> p0_rvalid one cycle after the read handshake, p0_rdata = 0xDEADBEEF.
- Byte-mask write: mem[0x010] = 0x11223344, then write 0xAABBCCDD with wmask 0x5 -> p1 read of 0x010 returns 0x11BB33DD.
- Backpressure: hold p0_rready = 0 and issue 3 back-to-back reads -> 2 accepted, p0_ready low on the 3rd. Release rready -> 3rd accepted and data returned in order.
- Conflict: same cycle p0 write addr 0x1FF and p1 read 0x1FF -> p1_ready = 0 that cycle. The p1 read issues next cycle and returns the written data.
- Reset with one read pending -> after reset, p0_rvalid stays 0, FIFO is empty, and sram_csb0 = sram_csb1 = 1.
- Wrap: 6 reads with rready always high on p1, addresses 0x1FD..0x002 -> 6 responses in order, 1 per cycle after the first.
